// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates one memory port between an instruction-fetch requester and a
// data requester. Data always wins when both ask in the same IDLE cycle.
// Each access walks IDLE -> BUSY -> RESP. The access ends in BUSY when the
// memory raises inputReady, or aborts with err=1 after TIMEOUT BUSY cycles.
//
// Ports
//   clk, reset                  single clock, asynchronous active-high reset
//   f_req, f_addr               fetch request (always a read)
//   f_done, f_rdata             fetch completion pulse and fetched word
//   d_req, d_we, d_addr,
//   d_wdata                     data request: direction, address, store data
//   d_done, d_rdata             data completion pulse and load data
//   err                         timeout flag, only meaningful with a done pulse
//   readM, writeM, address,
//   mem_wdata, mem_rdata,
//   inputReady                  memory-side handshake
//   busy                        high whenever an access is in progress
//   acc_count                   count of error-free completed accesses
module mem_port_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int TIMEOUT   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 f_req,
    input  logic [WORD_SIZE-1:0] f_addr,
    output logic                 f_done,
    output logic [WORD_SIZE-1:0] f_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_done,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 err,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 inputReady,
    output logic                 busy,
    output logic [WORD_SIZE-1:0] acc_count
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state, state_next;
    logic                own_data, own_data_next;
    logic                we_q, we_next;
    logic [WAIT_W-1:0]   wait_cnt, wait_next;
    logic                read_next, write_next, busy_next;
    logic                f_done_next, d_done_next, err_next;
    logic [WORD_SIZE-1:0] address_next, wdata_next;
    logic [WORD_SIZE-1:0] f_rdata_next, d_rdata_next, acc_next;

    // State and every output are flops; the combinational process below
    // decides the value each one takes at the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            own_data  <= 1'b0;
            we_q      <= 1'b0;
            wait_cnt  <= '0;
            readM     <= 1'b0;
            writeM    <= 1'b0;
            busy      <= 1'b0;
            f_done    <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
            address   <= '0;
            mem_wdata <= '0;
            f_rdata   <= '0;
            d_rdata   <= '0;
            acc_count <= '0;
        end else begin
            state     <= state_next;
            own_data  <= own_data_next;
            we_q      <= we_next;
            wait_cnt  <= wait_next;
            readM     <= read_next;
            writeM    <= write_next;
            busy      <= busy_next;
            f_done    <= f_done_next;
            d_done    <= d_done_next;
            err       <= err_next;
            address   <= address_next;
            mem_wdata <= wdata_next;
            f_rdata   <= f_rdata_next;
            d_rdata   <= d_rdata_next;
            acc_count <= acc_next;
        end
    end

    // Next-state and next-output logic. The request attributes are captured
    // on grant, so requester changes during BUSY never reach the memory.
    // A timed-out write leaves d_rdata alone, because writes never touch it.
    always_comb begin
        state_next    = state;
        own_data_next = own_data;
        we_next       = we_q;
        wait_next     = wait_cnt;
        read_next     = readM;
        write_next    = writeM;
        busy_next     = busy;
        f_done_next   = 1'b0;
        d_done_next   = 1'b0;
        err_next      = 1'b0;
        address_next  = address;
        wdata_next    = mem_wdata;
        f_rdata_next  = f_rdata;
        d_rdata_next  = d_rdata;
        acc_next      = acc_count;

        case (state)
            IDLE: begin
                if (d_req || f_req) begin
                    state_next    = BUSY;
                    busy_next     = 1'b1;
                    wait_next     = '0;
                    own_data_next = d_req;
                    we_next       = d_req & d_we;
                    address_next  = d_req ? d_addr : f_addr;
                    wdata_next    = d_req ? d_wdata : '0;
                    read_next     = ~(d_req & d_we);
                    write_next    = d_req & d_we;
                end
            end
            BUSY: begin
                if (inputReady) begin
                    state_next = RESP;
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    acc_next   = acc_count + 1'b1;
                    if (own_data) begin
                        d_done_next = 1'b1;
                        if (!we_q) begin
                            d_rdata_next = mem_rdata;
                        end
                    end else begin
                        f_done_next  = 1'b1;
                        f_rdata_next = mem_rdata;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next = RESP;
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    err_next   = 1'b1;
                    if (own_data) begin
                        d_done_next = 1'b1;
                        if (!we_q) begin
                            d_rdata_next = '0;
                        end
                    end else begin
                        f_done_next  = 1'b1;
                        f_rdata_next = '0;
                    end
                end else begin
                    wait_next = wait_cnt + 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                read_next  = 1'b0;
                write_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with default parameters (16-bit words,
// timeout of 8 BUSY cycles). Inputs change 1ns after a rising edge and
// outputs are checked at that same point, so every check sees settled flops.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_done;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        err;
    logic        readM;
    logic        writeM;
    logic [15:0] address;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        inputReady;
    logic        busy;
    logic [15:0] acc_count;

    int testsRun;
    int testsFailed;

    mem_port_arbiter #(
        .WORD_SIZE(16),
        .TIMEOUT  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_done    (f_done),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .err       (err),
        .readM     (readM),
        .writeM    (writeM),
        .address   (address),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .inputReady(inputReady),
        .busy      (busy),
        .acc_count (acc_count)
    );

    // Free-running 10ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic        fReq,
        input logic [15:0] fAddr,
        input logic        dReq,
        input logic        dWe,
        input logic [15:0] dAddr,
        input logic [15:0] dWdata,
        input logic        ready,
        input logic [15:0] rdata
    );
        f_req      = fReq;
        f_addr     = fAddr;
        d_req      = dReq;
        d_we       = dWe;
        d_addr     = dAddr;
        d_wdata    = dWdata;
        inputReady = ready;
        mem_rdata  = rdata;
    endtask

    task automatic checkOutput(
        input string       tag,
        input logic [31:0] observed,
        input logic [31:0] expected
    );
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence: reset, fetch, priority, timeout, reset mid-access,
    // spurious inputReady.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick;
        tick;
        checkOutput("rst_readM", readM, 0);
        checkOutput("rst_writeM", writeM, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", {f_done, d_done, err}, 0);
        checkOutput("rst_address", address, 0);
        checkOutput("rst_acc", acc_count, 0);
        reset = 1'b0;

        // Fetch read, memory ready on the second BUSY cycle.
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick;
        checkOutput("f_busy1_readM", readM, 1);
        checkOutput("f_busy1_writeM", writeM, 0);
        checkOutput("f_busy1_addr", address, 16'h0010);
        checkOutput("f_busy1_busy", busy, 1);
        tick;
        checkOutput("f_busy2_readM", readM, 1);
        checkOutput("f_busy2_done", f_done, 0);
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h6A01);
        tick;
        checkOutput("f_resp_done", f_done, 1);
        checkOutput("f_resp_rdata", f_rdata, 16'h6A01);
        checkOutput("f_resp_readM", readM, 0);
        checkOutput("f_resp_err", err, 0);
        checkOutput("f_resp_ddone", d_done, 0);
        checkOutput("f_resp_acc", acc_count, 1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick;
        checkOutput("f_idle_done", f_done, 0);
        checkOutput("f_idle_busy", busy, 0);

        // Both request together: data write first, then the pending fetch.
        applyStimulus(1'b1, 16'h0030, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 16'h0);
        tick;
        checkOutput("p_w_writeM", writeM, 1);
        checkOutput("p_w_readM", readM, 0);
        checkOutput("p_w_addr", address, 16'h0020);
        checkOutput("p_w_wdata", mem_wdata, 16'hBEEF);
        applyStimulus(1'b1, 16'h0030, 1'b1, 1'b1, 16'h0020, 16'hBEEF, 1'b1, 16'hDEAD);
        tick;
        checkOutput("p_w_ddone", d_done, 1);
        checkOutput("p_w_fdone", f_done, 0);
        checkOutput("p_w_writeM_off", writeM, 0);
        checkOutput("p_w_drdata_kept", d_rdata, 0);
        checkOutput("p_w_acc", acc_count, 2);
        applyStimulus(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick;
        checkOutput("p_idle_ddone", d_done, 0);
        tick;
        checkOutput("p_f_readM", readM, 1);
        checkOutput("p_f_addr", address, 16'h0030);
        applyStimulus(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h1234);
        tick;
        checkOutput("p_f_done", f_done, 1);
        checkOutput("p_f_rdata", f_rdata, 16'h1234);
        checkOutput("p_f_acc", acc_count, 3);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick;

        // Normal data read so d_rdata holds something before the timeout.
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 16'h0);
        tick;
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0050, 16'h0, 1'b1, 16'h5555);
        tick;
        checkOutput("r_ddone", d_done, 1);
        checkOutput("r_drdata", d_rdata, 16'h5555);
        checkOutput("r_acc", acc_count, 4);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick;

        // Data read that never sees inputReady: aborts after 8 BUSY cycles.
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h0);
        tick;
        for (int i = 0; i < 7; i++) tick;
        checkOutput("t_busy8_readM", readM, 1);
        checkOutput("t_busy8_done", d_done, 0);
        tick;
        checkOutput("t_ddone", d_done, 1);
        checkOutput("t_err", err, 1);
        checkOutput("t_drdata", d_rdata, 0);
        checkOutput("t_acc", acc_count, 4);
        checkOutput("t_readM", readM, 0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick;
        checkOutput("t_idle_err", err, 0);
        applyStimulus(1'b1, 16'h0060, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick;
        applyStimulus(1'b1, 16'h0060, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0ABC);
        tick;
        checkOutput("t_next_fdone", f_done, 1);
        checkOutput("t_next_err", err, 0);
        checkOutput("t_next_rdata", f_rdata, 16'h0ABC);
        checkOutput("t_next_acc", acc_count, 5);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick;

        // Reset asserted in the middle of a BUSY read.
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0070, 16'h0, 1'b0, 16'h0);
        tick;
        checkOutput("m_readM_before", readM, 1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("m_readM_async", readM, 0);
        checkOutput("m_busy_async", busy, 0);
        checkOutput("m_acc_async", acc_count, 0);
        checkOutput("m_addr_async", address, 0);
        tick;
        checkOutput("m_no_done", d_done, 0);
        reset = 1'b0;
        tick;
        checkOutput("m_regrant_readM", readM, 1);
        checkOutput("m_regrant_addr", address, 16'h0070);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0070, 16'h0, 1'b1, 16'h7777);
        tick;
        checkOutput("m_ddone", d_done, 1);
        checkOutput("m_drdata", d_rdata, 16'h7777);
        checkOutput("m_acc", acc_count, 1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick;

        // inputReady while idle with no requesters is ignored.
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'hFFFF);
        tick;
        tick;
        checkOutput("s_busy", busy, 0);
        checkOutput("s_done", {f_done, d_done}, 0);
        checkOutput("s_acc", acc_count, 1);
        checkOutput("s_readM", readM, 0);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
